// File: rtl/div5_pkg.sv
// Shared widths and FSM state encoding for the 5-bit restoring divider.
package div5_pkg;

    localparam int DIV_W = 5;   // dividend, divisor, quotient width
    localparam int REM_W = 6;   // partial remainder / trial subtraction width
    localparam int STEPS = 5;   // one restoring step per dividend bit
    localparam int CNT_W = 3;   // step counter width, holds 0..STEPS-1

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/sub_borrow6.sv
// 6-bit ripple-borrow subtractor: diff = a - b.
// borrow_out = 0 means a >= b.
module sub_borrow6
    import div5_pkg::*;
(
    input  logic [REM_W-1:0] a,
    input  logic [REM_W-1:0] b,
    output logic [REM_W-1:0] diff,
    output logic             borrow_out
);

    logic [REM_W:0] bw;

    // Bitwise full-subtractor chain, LSB first.
    always_comb begin
        diff  = '0;
        bw    = '0;
        bw[0] = 1'b0;
        for (int i = 0; i < REM_W; i++) begin
            diff[i]  = a[i] ^ b[i] ^ bw[i];
            bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
        borrow_out = bw[REM_W];
    end

endmodule

// File: rtl/restoring_div5.sv
// 5-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional build macro DIV_ZERO_FAST_EN: a divide-by-zero request skips the
// CALC steps and goes straight to DONE with the saturated result.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | in_ready high, waiting for an operand pair
//   S_CALC | one restoring step per edge, STEPS edges total
//   S_DONE | out_valid high, result held until out_ready
module restoring_div5
    import div5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [DIV_W-1:0] dvd_r;
    logic [DIV_W-1:0] dvs_r;
    logic [REM_W-1:0] rem_r;
    logic [DIV_W-1:0] quo_r;
    logic [CNT_W-1:0] step;

    logic [REM_W-1:0] r6;
    logic [REM_W-1:0] trial_diff;
    logic             trial_borrow;
    logic [REM_W-1:0] rem_nxt;
    logic [DIV_W-1:0] quo_nxt;

    // Shift the next dividend bit into the partial remainder; the remainder
    // never exceeds the divisor so its top bit is dropped by the truncation.
    always_comb begin
        r6      = REM_W'({rem_r, dvd_r[DIV_W-1]});
        rem_nxt = trial_borrow ? r6 : trial_diff;
        quo_nxt = DIV_W'({quo_r, ~trial_borrow});
    end

    sub_borrow6 u_sub (
        .a          (r6),
        .b          ({1'b0, dvs_r}),
        .diff       (trial_diff),
        .borrow_out (trial_borrow)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            step        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        dvd_r    <= dividend;
                        dvs_r    <= divisor;
                        rem_r    <= '0;
                        quo_r    <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    dvd_r <= dvd_r << 1;
                    step  <= step + 1'b1;
                    if (step == CNT_W'(STEPS - 1)) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= quo_nxt;
                        remainder   <= DIV_W'(rem_nxt);
                        div_by_zero <= (dvs_r == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state       <= S_IDLE;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
